// File: rtl/dtm_jtag_pkg.sv
// Shared debug-transport definitions: TAP state encoding, IR codes, DMI ops
// and DTMCS field layout.
package dtm_jtag_pkg;

   typedef enum logic [3:0] {
      TAP_TLR,
      TAP_RTI,
      TAP_SEL_DR,
      TAP_CAP_DR,
      TAP_SH_DR,
      TAP_EX1_DR,
      TAP_PAUSE_DR,
      TAP_EX2_DR,
      TAP_UPD_DR,
      TAP_SEL_IR,
      TAP_CAP_IR,
      TAP_SH_IR,
      TAP_EX1_IR,
      TAP_PAUSE_IR,
      TAP_EX2_IR,
      TAP_UPD_IR
   } tap_state_e;

   localparam logic [4:0] IR_IDCODE  = 5'h01;
   localparam logic [4:0] IR_DTMCS   = 5'h10;
   localparam logic [4:0] IR_DMI     = 5'h11;
   localparam logic [4:0] IR_BYPASS  = 5'h1F;
   localparam logic [4:0] IR_CAPTURE = 5'b00001;

   localparam logic [1:0] DMI_OP_NOP   = 2'd0;
   localparam logic [1:0] DMI_OP_READ  = 2'd1;
   localparam logic [1:0] DMI_OP_WRITE = 2'd2;
   localparam logic [1:0] DMI_OP_RSVD  = 2'd3;
   localparam logic [1:0] DMISTAT_BUSY = 2'd3;

   localparam int unsigned DR_W        = 41;
   localparam int unsigned DMI_ADDR_HI = 40;
   localparam int unsigned DMI_ADDR_LO = 34;
   localparam int unsigned DMI_DATA_HI = 33;
   localparam int unsigned DMI_DATA_LO = 2;

   localparam int unsigned DTMCS_DMIRESET  = 16;
   localparam int unsigned DTMCS_HARDRESET = 17;
   localparam logic [5:0]  DTMCS_ABITS     = 6'd7;
   localparam logic [3:0]  DTMCS_VERSION   = 4'd1;

   function automatic logic [31:0] dtmcs_word(input logic [2:0] idle,
                                              input logic [1:0] stat);
      return {14'b0, 1'b0, 1'b0, 1'b0, idle, stat, DTMCS_ABITS, DTMCS_VERSION};
   endfunction

endpackage

// File: rtl/dtm_jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller stepped by oversampled TCK rising edges.
module jtag_tap_fsm
   import dtm_jtag_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       tck_rise,
   input  logic       tms,
   output tap_state_e state,
   output logic       capture_dr,
   output logic       shift_dr,
   output logic       update_dr,
   output logic       capture_ir,
   output logic       shift_ir,
   output logic       update_ir
);

   tap_state_e state_next;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= TAP_TLR;
      else if (tck_rise) state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         TAP_TLR:      state_next = tms ? TAP_TLR      : TAP_RTI;
         TAP_RTI:      state_next = tms ? TAP_SEL_DR   : TAP_RTI;
         TAP_SEL_DR:   state_next = tms ? TAP_SEL_IR   : TAP_CAP_DR;
         TAP_CAP_DR:   state_next = tms ? TAP_EX1_DR   : TAP_SH_DR;
         TAP_SH_DR:    state_next = tms ? TAP_EX1_DR   : TAP_SH_DR;
         TAP_EX1_DR:   state_next = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
         TAP_PAUSE_DR: state_next = tms ? TAP_EX2_DR   : TAP_PAUSE_DR;
         TAP_EX2_DR:   state_next = tms ? TAP_UPD_DR   : TAP_SH_DR;
         TAP_UPD_DR:   state_next = tms ? TAP_SEL_DR   : TAP_RTI;
         TAP_SEL_IR:   state_next = tms ? TAP_TLR      : TAP_CAP_IR;
         TAP_CAP_IR:   state_next = tms ? TAP_EX1_IR   : TAP_SH_IR;
         TAP_SH_IR:    state_next = tms ? TAP_EX1_IR   : TAP_SH_IR;
         TAP_EX1_IR:   state_next = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
         TAP_PAUSE_IR: state_next = tms ? TAP_EX2_IR   : TAP_PAUSE_IR;
         TAP_EX2_IR:   state_next = tms ? TAP_UPD_IR   : TAP_SH_IR;
         TAP_UPD_IR:   state_next = tms ? TAP_SEL_DR   : TAP_RTI;
         default:      state_next = TAP_TLR;
      endcase
   end

   // Strobes fire on the TCK rise that leaves the named state.
   always_comb begin
      capture_dr = tck_rise && (state == TAP_CAP_DR);
      shift_dr   = tck_rise && (state == TAP_SH_DR);
      update_dr  = tck_rise && (state == TAP_UPD_DR);
      capture_ir = tck_rise && (state == TAP_CAP_IR);
      shift_ir   = tck_rise && (state == TAP_SH_IR);
      update_ir  = tck_rise && (state == TAP_UPD_IR);
   end

endmodule

// File: rtl/dtm_jtag.sv
// JTAG debug transport module: oversampled TAP, IDCODE/DTMCS/DMI/BYPASS
// data registers and a single-outstanding DMI master port.
module dtm_jtag
   import dtm_jtag_pkg::*;
#(
   parameter logic [31:0] IDCODE    = 32'h1000_0001,
   parameter logic [2:0]  IDLE_HINT = 3'd1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        jtag_tck,
   input  logic        jtag_tms,
   input  logic        jtag_tdi,
   output logic        jtag_tdo,
   output logic        dmi_valid,
   input  logic        dmi_ready,
   output logic        dmi_write,
   output logic [6:0]  dmi_addr,
   output logic [31:0] dmi_wdata,
   input  logic [31:0] dmi_rdata
);

   logic tck_s1, tck_s2, tck_d;
   logic tms_s1, tms_s2;
   logic tdi_s1, tdi_s2;
   logic tck_rise, tck_fall;

   tap_state_e tap_state;
   logic capture_dr, shift_dr, update_dr;
   logic capture_ir, shift_ir, update_ir;

   logic [4:0]      ir, ir_sr;
   logic [DR_W-1:0] dr, dr_shifted;
   logic [1:0]      dmistat;
   logic [31:0]     rdata_q;
   logic            discard;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         {tck_s1, tck_s2, tck_d} <= '0;
         {tms_s1, tms_s2}        <= '0;
         {tdi_s1, tdi_s2}        <= '0;
      end else begin
         tck_s1 <= jtag_tck;
         tck_s2 <= tck_s1;
         tck_d  <= tck_s2;
         tms_s1 <= jtag_tms;
         tms_s2 <= tms_s1;
         tdi_s1 <= jtag_tdi;
         tdi_s2 <= tdi_s1;
      end
   end

   assign tck_rise = tck_s2 & ~tck_d;
   assign tck_fall = ~tck_s2 & tck_d;

   jtag_tap_fsm u_tap (
      .clk        (clk),
      .resetn     (resetn),
      .tck_rise   (tck_rise),
      .tms        (tms_s2),
      .state      (tap_state),
      .capture_dr (capture_dr),
      .shift_dr   (shift_dr),
      .update_dr  (update_dr),
      .capture_ir (capture_ir),
      .shift_ir   (shift_ir),
      .update_ir  (update_ir)
   );

   // TDI enters at the top of the currently selected register length.
   always_comb begin
      dr_shifted = '0;
      case (ir)
         IR_DMI:              dr_shifted = {tdi_s2, dr[DR_W-1:1]};
         IR_IDCODE, IR_DTMCS: dr_shifted = {9'b0, tdi_s2, dr[31:1]};
         default:             dr_shifted = {40'b0, tdi_s2};
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ir       <= IR_IDCODE;
         ir_sr    <= '0;
         jtag_tdo <= 1'b0;
      end else begin
         if (tap_state == TAP_TLR) ir <= IR_IDCODE;
         else if (update_ir)       ir <= ir_sr;

         if (capture_ir)    ir_sr <= IR_CAPTURE;
         else if (shift_ir) ir_sr <= {tdi_s2, ir_sr[4:1]};

         if (tck_fall) begin
            if (tap_state == TAP_SH_DR)      jtag_tdo <= dr[0];
            else if (tap_state == TAP_SH_IR) jtag_tdo <= ir_sr[0];
         end
      end
   end

   // Capture, DMI update and the handshake share one block because all three
   // touch dmistat; later assignments take priority within a cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dr        <= '0;
         dmistat   <= '0;
         rdata_q   <= '0;
         discard   <= 1'b0;
         dmi_valid <= 1'b0;
         dmi_write <= 1'b0;
         dmi_addr  <= '0;
         dmi_wdata <= '0;
      end else begin
         if (capture_dr) begin
            case (ir)
               IR_IDCODE: dr <= {9'b0, IDCODE};
               IR_DTMCS:  dr <= {9'b0, dtmcs_word(IDLE_HINT, dmistat)};
               IR_DMI: begin
                  dr <= {dmi_addr, rdata_q, (dmi_valid ? DMISTAT_BUSY : dmistat)};
                  if (dmi_valid) dmistat <= DMISTAT_BUSY;
               end
               IR_BYPASS: dr <= '0;
               default:   dr <= '0;
            endcase
         end else if (shift_dr) begin
            dr <= dr_shifted;
         end

         if (dmi_valid && dmi_ready) begin
            dmi_valid <= 1'b0;
            discard   <= 1'b0;
            if (!dmi_write && !discard) rdata_q <= dmi_rdata;
         end

         if (update_dr) begin
            case (ir)
               IR_DTMCS: begin
                  if (dr[DTMCS_DMIRESET] || dr[DTMCS_HARDRESET]) dmistat <= '0;
                  if (dr[DTMCS_HARDRESET] && dmi_valid && !dmi_ready) discard <= 1'b1;
               end
               IR_DMI: begin
                  if (dmistat == '0) begin
                     case (dr[1:0])
                        DMI_OP_READ, DMI_OP_WRITE: begin
                           if (dmi_valid) begin
                              dmistat <= DMISTAT_BUSY;
                           end else begin
                              dmi_valid <= 1'b1;
                              dmi_write <= (dr[1:0] == DMI_OP_WRITE);
                              dmi_addr  <= dr[DMI_ADDR_HI:DMI_ADDR_LO];
                              dmi_wdata <= dr[DMI_DATA_HI:DMI_DATA_LO];
                              discard   <= 1'b0;
                           end
                        end
                        DMI_OP_NOP, DMI_OP_RSVD: ;
                        default: ;
                     endcase
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dtm_jtag.sv
// Directed bench for dtm_jtag: bit-banged JTAG scans with a scoreboard of
// expected scan-out words and expected DMI requests.
module tb_dtm_jtag;

   typedef struct packed {
      logic        w;
      logic [6:0]  a;
      logic [31:0] d;
   } req_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        jtag_tck = 1'b0;
   logic        jtag_tms = 1'b0;
   logic        jtag_tdi = 1'b0;
   logic        jtag_tdo;
   logic        dmi_valid;
   logic        dmi_ready = 1'b0;
   logic        dmi_write;
   logic [6:0]  dmi_addr;
   logic [31:0] dmi_wdata;
   logic [31:0] dmi_rdata = '0;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned handshakes = 0;
   int unsigned valid_rises = 0;
   int unsigned ready_delay = 2;
   logic        hold_ready = 1'b0;
   logic [31:0] rdata_val = '0;

   logic [40:0] scan_q[$];
   req_t        req_q[$];

   dtm_jtag #(.IDCODE(32'h1000_0001), .IDLE_HINT(3'd1)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .jtag_tck  (jtag_tck),
      .jtag_tms  (jtag_tms),
      .jtag_tdi  (jtag_tdi),
      .jtag_tdo  (jtag_tdo),
      .dmi_valid (dmi_valid),
      .dmi_ready (dmi_ready),
      .dmi_write (dmi_write),
      .dmi_addr  (dmi_addr),
      .dmi_wdata (dmi_wdata),
      .dmi_rdata (dmi_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [40:0] obs, input logic [40:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Debug-module model: asserts ready after a delay unless held off.
   int unsigned wait_cnt = 0;
   logic        valid_prev = 1'b0;
   req_t        snap, cur, exp_req;
   always @(negedge clk) begin
      if (!resetn) begin
         dmi_ready  = 1'b0;
         wait_cnt   = 0;
         valid_prev = 1'b0;
      end else begin
         cur = {dmi_write, dmi_addr, dmi_wdata};
         if (dmi_ready) begin
            dmi_ready = 1'b0;
            wait_cnt  = 0;
         end else if (dmi_valid) begin
            if (!valid_prev) begin
               valid_rises++;
               snap = cur;
            end else begin
               check("dmi_stable", {1'b0, cur}, {1'b0, snap});
            end
            if (!hold_ready && wait_cnt >= ready_delay) begin
               if (req_q.size() == 0) begin
                  checks++;
                  errors++;
                  $error("FAIL dmi_unexpected: observed %h expected none", cur);
               end else begin
                  exp_req = req_q.pop_front();
                  check("dmi_req", {1'b0, cur}, {1'b0, exp_req});
               end
               dmi_rdata = rdata_val;
               dmi_ready = 1'b1;
               handshakes++;
            end else begin
               wait_cnt++;
            end
         end
         valid_prev = dmi_valid;
      end
   end

   task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
      jtag_tms = tms;
      jtag_tdi = tdi;
      tdo = jtag_tdo;
      @(negedge clk);
      jtag_tck = 1'b1;
      repeat (6) @(negedge clk);
      jtag_tck = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic tck_n(input logic tms, input int unsigned n);
      logic b;
      for (int unsigned i = 0; i < n; i++) tck_cycle(tms, 1'b0, b);
   endtask

   task automatic dr_scan(input int unsigned n, input logic [40:0] din, output logic [40:0] dout);
      logic b;
      dout = '0;
      tck_n(1'b1, 1);
      tck_n(1'b0, 2);
      for (int unsigned i = 0; i < n; i++) begin
         tck_cycle(i == n - 1, din[i], b);
         dout[i] = b;
      end
      tck_n(1'b1, 1);
      tck_n(1'b0, 1);
   endtask

   task automatic ir_scan(input logic [4:0] ir, output logic [4:0] dout);
      logic b;
      dout = '0;
      tck_n(1'b1, 2);
      tck_n(1'b0, 2);
      for (int unsigned i = 0; i < 5; i++) begin
         tck_cycle(i == 4, ir[i], b);
         dout[i] = b;
      end
      tck_n(1'b1, 1);
      tck_n(1'b0, 1);
   endtask

   task automatic scan_check(input string tag, input int unsigned n,
                             input logic [40:0] din, input logic [40:0] exp);
      logic [40:0] got;
      scan_q.push_back(exp);
      dr_scan(n, din, got);
      check(tag, got, scan_q.pop_front());
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation timeout");
   end

   initial begin
      logic [40:0] junk;
      logic [4:0]  irout;

      repeat (3) @(negedge clk);
      check("rst_tdo",   {40'b0, jtag_tdo},  41'd0);
      check("rst_valid", {40'b0, dmi_valid}, 41'd0);
      check("rst_write", {40'b0, dmi_write}, 41'd0);
      check("rst_addr",  {34'b0, dmi_addr},  41'd0);
      check("rst_wdata", {9'b0, dmi_wdata},  41'd0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // IDCODE from test-logic-reset
      tck_n(1'b1, 5);
      tck_n(1'b0, 1);
      scan_check("idcode", 32, '0, 41'h0_1000_0001);

      // DTMCS
      ir_scan(5'h10, irout);
      check("ir_capture", {36'b0, irout}, 41'd1);
      scan_check("dtmcs", 32, '0, 41'h0000_1071);

      // DMI write
      ir_scan(5'h11, irout);
      ready_delay = 3;
      req_q.push_back('{w: 1'b1, a: 7'h04, d: 32'hDEAD_BEEF});
      scan_check("dmi_wr_cap", 41, {7'h04, 32'hDEAD_BEEF, 2'd2}, 41'd0);
      tck_n(1'b0, 3);
      check("wr_handshakes", 41'(handshakes), 41'd1);
      check("wr_pulses", 41'(valid_rises), 41'd1);
      check("wr_valid_low", {40'b0, dmi_valid}, 41'd0);

      // DMI read, result visible in the following nop scan
      ready_delay = 1;
      rdata_val = 32'h1234_5678;
      req_q.push_back('{w: 1'b0, a: 7'h11, d: 32'h0});
      scan_check("dmi_rd_cap", 41, {7'h11, 32'h0, 2'd1}, {7'h04, 32'h0, 2'd0});
      tck_n(1'b0, 3);
      scan_check("dmi_rd_data", 41, '0, {7'h11, 32'h1234_5678, 2'd0});

      // Busy: first request held, second dropped
      hold_ready = 1'b1;
      req_q.push_back('{w: 1'b0, a: 7'h05, d: 32'h0});
      scan_check("busy_first", 41, {7'h05, 32'h0, 2'd1}, {7'h11, 32'h1234_5678, 2'd0});
      tck_n(1'b0, 2);
      check("busy_valid", {40'b0, dmi_valid}, 41'd1);
      scan_check("busy_cap", 41, {7'h06, 32'h0, 2'd1}, {7'h05, 32'h1234_5678, 2'd3});
      rdata_val = 32'hCAFE_0001;
      hold_ready = 1'b0;
      for (int i = 0; i < 200 && handshakes < 3; i++) @(negedge clk);
      check("busy_handshakes", 41'(handshakes), 41'd3);
      tck_n(1'b0, 3);
      check("busy_dropped", 41'(valid_rises), 41'd3);
      scan_check("busy_sticky", 41, '0, {7'h05, 32'hCAFE_0001, 2'd3});
      ir_scan(5'h10, irout);
      scan_check("dtmcs_busy", 32, 41'h0_0001_0000, 41'h0000_1C71);
      ir_scan(5'h11, irout);
      scan_check("busy_cleared", 41, '0, {7'h05, 32'hCAFE_0001, 2'd0});

      // Asynchronous reset mid-handshake while in Shift-DR
      hold_ready = 1'b1;
      dr_scan(41, {7'h07, 32'hA5A5_0000, 2'd2}, junk);
      tck_n(1'b0, 2);
      check("pre_rst_valid", {40'b0, dmi_valid}, 41'd1);
      tck_n(1'b1, 1);
      tck_n(1'b0, 2);
      check("pre_rst_tdo", {40'b0, jtag_tdo}, 41'd1);
      resetn = 1'b0;
      #1;
      check("async_valid", {40'b0, dmi_valid}, 41'd0);
      check("async_tdo",   {40'b0, jtag_tdo},  41'd0);
      check("async_addr",  {34'b0, dmi_addr},  41'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      hold_ready = 1'b0;
      @(negedge clk);
      tck_n(1'b0, 1);
      scan_check("idcode_after_rst", 32, '0, 41'h0_1000_0001);
      ir_scan(5'h1F, irout);
      scan_check("bypass", 8, 41'h0B2, 41'h064);
      check("req_q_empty", 41'(req_q.size()), 41'd0);
      check("final_handshakes", 41'(handshakes), 41'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
